// File: rtl/mem_burst_controller_pkg.sv
// Shared definitions for the memory burst controller and the cache blocks
// that sit upstream of it.
//   - default address/data/block geometry
//   - block offset width (word index within a cache block)
//   - controller state encoding
package mem_burst_controller_pkg;

  localparam int ADDR_W_DEF      = 16;
  localparam int DATA_W_DEF      = 16;
  localparam int BLOCK_WORDS_DEF = 8;
  localparam int BLOCK_OFF_W     = $clog2(BLOCK_WORDS_DEF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

endpackage

// File: rtl/mem_burst_controller_mem_array.sv
// Single-port synchronous RAM, DEPTH x DATA_W.
// Ports:
//   clk, rst  - clock; async active-high reset clears only the read register
//   i_we      - write enable (writes i_wdata to i_addr)
//   i_re      - read enable (loads o_rdata from i_addr on the next edge)
//   i_addr    - word address
//   i_wdata   - write data
//   o_rdata   - registered read data; holds its value while i_re is low
module mem_burst_controller_mem_array #(
  parameter int DEPTH  = 4096,
  parameter int DATA_W = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Storage is deliberately not reset; contents survive a controller reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_burst_controller.sv
// Memory-side stage behind the I/D-cache arbiter. Reads return a whole
// cache block as an ascending burst; writes are single-word write-through.
// Ports:
//   clk, rst        - clock, async active-high reset
//   mem_request     - request, sampled only while idle
//   mem_write       - 1 = single-word write, 0 = block read
//   mem_address_in  - byte address (bit 0 ignored)
//   mem_wdata       - write data
//   mem_busy        - high whenever a transaction is in progress
//   mem_data_valid  - burst word present on mem_data_out
//   mem_data_out    - burst word (holds when not valid)
//   mem_word_index  - index of the current burst word
//   mem_ready       - one-cycle completion pulse
//
// Handshake: a request is accepted at any edge where the block is idle and
// mem_request=1; request/address/data are latched there and ignored until
// the transaction ends. Completion is signalled by mem_ready for exactly one
// cycle (with the last burst word, or in the write-commit cycle). The block
// then spends at least one cycle idle before it can accept again.
module mem_burst_controller
  import mem_burst_controller_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int BLOCK_WORDS = BLOCK_WORDS_DEF,
  parameter int LATENCY     = 4,
  parameter int MEM_WORDS   = 4096
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           mem_request,
  input  logic                           mem_write,
  input  logic [ADDR_W-1:0]              mem_address_in,
  input  logic [DATA_W-1:0]              mem_wdata,
  output logic                           mem_busy,
  output logic                           mem_data_valid,
  output logic [DATA_W-1:0]              mem_data_out,
  output logic [$clog2(BLOCK_WORDS)-1:0] mem_word_index,
  output logic                           mem_ready
);

  localparam int OFF_W  = $clog2(BLOCK_WORDS);
  localparam int MEM_AW = $clog2(MEM_WORDS);
  localparam int CNT_W  = $clog2(LATENCY + 1);

  state_e              r_state;
  state_e              w_next_state;
  logic                r_write;
  logic [MEM_AW-1:0]   r_word_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [CNT_W-1:0]    r_wait_cnt;
  logic [OFF_W-1:0]    r_idx;

  logic                w_last_wait;
  logic                w_last_word;
  logic [OFF_W-1:0]    w_next_idx;
  logic                w_ram_we;
  logic                w_ram_re;
  logic [MEM_AW-1:0]   w_ram_addr;
  logic [DATA_W-1:0]   w_ram_rdata;
  logic                w_unused_addr_bits;

  // Byte bit 0 and bits above the store depth do not select a word.
  assign w_unused_addr_bits = ^{mem_address_in[0], mem_address_in[ADDR_W-1:MEM_AW+1]};

  assign w_last_wait = (r_state == ST_WAIT) && (r_wait_cnt == CNT_W'(1));
  assign w_last_word = (r_idx == OFF_W'(BLOCK_WORDS - 1));
  assign w_next_idx  = r_idx + OFF_W'(1);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (mem_request) w_next_state = ST_WAIT;
      ST_WAIT:  if (w_last_wait) w_next_state = r_write ? ST_WRITE : ST_BURST;
      ST_BURST: if (w_last_word) w_next_state = ST_IDLE;
      ST_WRITE: w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Outputs and RAM control. The RAM read is registered, so the address for
  // burst word i is issued in the cycle before it is shown: word 0 in the
  // last wait cycle, word i+1 while word i is on the output.
  always_comb begin
    mem_busy       = 1'b0;
    mem_data_valid = 1'b0;
    mem_ready      = 1'b0;
    mem_word_index = '0;
    w_ram_we       = 1'b0;
    w_ram_re       = 1'b0;
    w_ram_addr     = r_word_addr;
    case (r_state)
      ST_WAIT: begin
        mem_busy = 1'b1;
        if (w_last_wait && !r_write) begin
          w_ram_re   = 1'b1;
          w_ram_addr = {r_word_addr[MEM_AW-1:OFF_W], {OFF_W{1'b0}}};
        end
      end
      ST_BURST: begin
        mem_busy       = 1'b1;
        mem_data_valid = 1'b1;
        mem_word_index = r_idx;
        mem_ready      = w_last_word;
        w_ram_re       = !w_last_word;
        w_ram_addr     = {r_word_addr[MEM_AW-1:OFF_W], w_next_idx};
      end
      ST_WRITE: begin
        mem_busy  = 1'b1;
        mem_ready = 1'b1;
        w_ram_we  = 1'b1;
      end
      default: ;
    endcase
  end

  // Request latch, wait counter and burst index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_write     <= 1'b0;
      r_word_addr <= '0;
      r_wdata     <= '0;
      r_wait_cnt  <= '0;
      r_idx       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (mem_request) begin
          r_write     <= mem_write;
          r_word_addr <= mem_address_in[MEM_AW:1];
          r_wdata     <= mem_wdata;
          r_wait_cnt  <= CNT_W'(LATENCY);
          r_idx       <= '0;
        end
        ST_WAIT:  r_wait_cnt <= r_wait_cnt - CNT_W'(1);
        ST_BURST: r_idx      <= w_next_idx;
        default: ;
      endcase
    end
  end

  mem_burst_controller_mem_array #(
    .DEPTH  (MEM_WORDS),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_addr  (w_ram_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_rdata)
  );

  assign mem_data_out = w_ram_rdata;

endmodule

// File: tb/tb_mem_burst_controller.sv
module tb_mem_burst_controller;

  localparam int LAT = 4;
  localparam int BW  = 8;
  localparam int MW  = 4096;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_request;
  logic        mem_write;
  logic [15:0] mem_address_in;
  logic [15:0] mem_wdata;
  logic        mem_busy;
  logic        mem_data_valid;
  logic [15:0] mem_data_out;
  logic [2:0]  mem_word_index;
  logic        mem_ready;

  always #5 clk = ~clk;

  mem_burst_controller #(
    .ADDR_W(16), .DATA_W(16), .BLOCK_WORDS(BW), .LATENCY(LAT), .MEM_WORDS(MW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_request    (mem_request),
    .mem_write      (mem_write),
    .mem_address_in (mem_address_in),
    .mem_wdata      (mem_wdata),
    .mem_busy       (mem_busy),
    .mem_data_valid (mem_data_valid),
    .mem_data_out   (mem_data_out),
    .mem_word_index (mem_word_index),
    .mem_ready      (mem_ready)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  int          ready_cnt = 0;
  int          word_cnt = 0;
  // entry = {valid, ready, index, data}
  logic [20:0] exp_q[$];
  logic [15:0] model_mem [MW];
  logic [20:0] act_v;
  logic [20:0] exp_v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int word_of(input logic [15:0] a);
    return (int'(a) >> 1) % MW;
  endfunction

  function automatic logic [15:0] rand_addr();
    // Upper bits random to exercise wrap modulo the store depth; word 0..63.
    return {3'($urandom_range(0, 7)), 13'($urandom_range(0, 127))};
  endfunction

  task automatic push_read(input logic [15:0] addr);
    int base;
    base = word_of(addr) & ~(BW - 1);
    for (int i = 0; i < BW; i++)
      exp_q.push_back({1'b1, (i == BW - 1), 3'(i), model_mem[base + i]});
  endtask

  task automatic push_write(input logic [15:0] addr, input logic [15:0] wd);
    model_mem[word_of(addr)] = wd;
    exp_q.push_back({1'b0, 1'b1, 3'd0, 16'h0});
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst && (mem_data_valid || mem_ready)) begin
      act_v = {mem_data_valid, mem_ready, mem_word_index,
               mem_data_valid ? mem_data_out : 16'h0};
      if (mem_ready) ready_cnt++;
      if (mem_data_valid) word_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_output: got %h expected nothing", act_v);
      end else begin
        exp_v = exp_q.pop_front();
        check("output_word", {11'h0, act_v}, {11'h0, exp_v});
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_txn(input logic wr, input logic [15:0] addr,
                        input logic [15:0] wd, input bit scramble);
    int first_n;
    int ready_n;
    first_n = 0;
    ready_n = 0;
    @(negedge clk);
    check("idle_before_req", mem_busy, 0);
    mem_request    = 1'b1;
    mem_write      = wr;
    mem_address_in = addr;
    mem_wdata      = wd;
    if (wr) push_write(addr, wd);
    else    push_read(addr);
    @(posedge clk);
    #1;
    mem_request = 1'b0;
    if (scramble) begin
      mem_address_in = 16'($urandom);
      mem_wdata      = 16'($urandom);
    end
    for (int n = 1; n <= 40 && ready_n == 0; n++) begin
      @(negedge clk);
      if (n == 1) check("busy_in_wait", mem_busy, 1);
      if (scramble && n == 2) begin
        mem_address_in = 16'($urandom);
        mem_write      = 1'($urandom);
      end
      if ((mem_data_valid || mem_ready) && first_n == 0) first_n = n;
      if (mem_ready) ready_n = n;
    end
    check("first_latency", first_n, LAT + 1);
    check("ready_latency", ready_n, wr ? LAT + 1 : LAT + BW);
    @(negedge clk);
    check("idle_after_ready", mem_busy, 0);
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, {8'h0, mem_busy, mem_data_valid, mem_ready, mem_word_index, mem_data_out}, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] a;
    int r0;
    int w0;
    rst = 1'b1;
    mem_request = 1'b0;
    mem_write = 1'b0;
    mem_address_in = '0;
    mem_wdata = '0;
    #1;
    check_outputs_zero("reset_outputs");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_outputs_zero("idle_after_reset");
    end

    // Preload the words the bench reads so every expected value is known.
    for (int w = 0; w < 64; w++)
      do_txn(1'b1, {3'($urandom_range(0, 7)), 13'(2 * w + $urandom_range(0, 1))},
             16'($urandom), 1'b0);

    // Directed: write then read of the same block, unaligned read.
    do_txn(1'b1, 16'h0024, 16'hBEEF, 1'b0);
    do_txn(1'b0, 16'h0020, 16'h0000, 1'b0);
    do_txn(1'b0, 16'h003F, 16'h0000, 1'b0);

    // Request held high through and after ready.
    @(negedge clk);
    a = rand_addr();
    mem_request = 1'b1;
    mem_write = 1'b0;
    mem_address_in = a;
    push_read(a);
    push_read(a);
    r0 = ready_cnt;
    for (int n = 0; n < 40 && ready_cnt == r0; n++) begin
      @(negedge clk);
      #1;
    end
    check("held_first_ready", ready_cnt, r0 + 1);
    @(negedge clk);
    check("held_idle_gap", mem_busy, 0);
    @(negedge clk);
    check("held_reissue", mem_busy, 1);
    mem_request = 1'b0;
    for (int n = 0; n < 40 && ready_cnt == r0 + 1; n++) begin
      @(negedge clk);
      #1;
    end
    check("held_second_ready", ready_cnt, r0 + 2);
    repeat (3) @(negedge clk);
    check("held_no_extra_ready", ready_cnt, r0 + 2);
    check("held_idle_end", mem_busy, 0);

    // Request dropped and address/write changed during the wait.
    do_txn(1'b0, rand_addr(), 16'h0, 1'b1);

    // Randomized mix.
    for (int t = 0; t < 40; t++)
      do_txn(1'($urandom_range(0, 1)), rand_addr(), 16'($urandom),
             1'($urandom_range(0, 1)));

    // Async reset between the third and fourth burst words.
    @(negedge clk);
    a = rand_addr();
    mem_request = 1'b1;
    mem_write = 1'b0;
    mem_address_in = a;
    push_read(a);
    @(posedge clk);
    #1;
    mem_request = 1'b0;
    w0 = word_cnt;
    r0 = ready_cnt;
    for (int n = 0; n < 40 && word_cnt < w0 + 3; n++) begin
      @(negedge clk);
      #1;
    end
    check("words_before_reset", word_cnt, w0 + 3);
    rst = 1'b1;
    #1;
    check_outputs_zero("reset_mid_burst");
    exp_q.delete();
    @(negedge clk);
    check_outputs_zero("reset_held");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("no_partial_ready", ready_cnt, r0);
    check("idle_after_mid_reset", mem_busy, 0);
    do_txn(1'b0, a, 16'h0, 1'b0);

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
